// File: rtl/md_unit_if.sv
// md_unit_if: operand/result bundle between the execute-stage control and the
// multiply/divide unit.
//   start     - qualifies md_op as a new operation this cycle
//   md_op     - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a, b      - rs / rt operands
//   busy      - registered, high while a mult/div is in flight
//   hi, lo    - committed HI/LO registers
//   dbg_state - FSM state (0 idle, 1 run) for observation
// Handshake: the unit accepts start only when busy is low. start while busy is
// high is ignored, so the issuing side holds off (start | busy) externally.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output start, md_op, a, b,
    input  busy, hi, lo, dbg_state
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, hi, lo, dbg_state
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: MIPS multiply/divide unit with architectural HI/LO registers.
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; clears all state and aborts any operation
//   bus   - md_unit_if.slave (start/md_op/a/b in, busy/hi/lo/dbg_state out)
// The result is computed combinationally at the accept edge and parked in
// pending registers; busy then models the fixed multi-cycle latency and the
// pending values are committed to HI/LO on the edge busy falls.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_wr;

  // Multipliers: both operands widened to 64 bits so the full product is kept.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  assign w_prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Divider: a zero divisor is replaced by 1 so the arithmetic stays defined;
  // that result is never committed. Signed division runs on magnitudes, which
  // makes 0x80000000 / -1 come out as 0x80000000 rem 0 without overflow.
  logic        w_b_zero;
  logic [31:0] w_div_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  assign w_b_zero = (bus.b == 32'd0);
  assign w_div_b  = w_b_zero ? 32'd1 : bus.b;
  assign w_abs_a  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign w_abs_b  = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
  assign w_uq     = w_abs_a / w_abs_b;
  assign w_ur     = w_abs_a % w_abs_b;
  // Quotient negative when signs differ; remainder follows the dividend.
  assign w_sq     = (bus.a[31] ^ w_div_b[31]) ? (32'd0 - w_uq) : w_uq;
  assign w_sr     = bus.a[31] ? (32'd0 - w_ur) : w_ur;
  assign w_q_u    = bus.a / w_div_b;
  assign w_r_u    = bus.a % w_div_b;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (bus.md_op)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV:   begin w_res_hi = w_sr;            w_res_lo = w_sq;           end
      OP_DIVU:  begin w_res_hi = w_r_u;           w_res_lo = w_q_u;          end
      default:  begin w_res_hi = 32'd0;           w_res_lo = 32'd0;          end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              OP_MULT, OP_MULTU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_wr <= 1'b1;
                r_cnt     <= MULT_LOAD;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                // Divide by zero still takes the full latency but never commits.
                r_pend_wr <= ~w_b_zero;
                r_cnt     <= DIV_LOAD;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              OP_MTHI: r_hi <= bus.a;
              OP_MTLO: r_lo <= bus.a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // start is ignored here: nothing in this branch looks at it.
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the MIPS datapath, sitting beside the ALU in the execute stage and consuming the same rs/rt operands from the GRF read ports. It executes mult/multu/div/divu over a fixed multi-cycle latency, holds the results in internal HI/LO registers, and serves mthi/mtlo/mfhi/mflo. A registered `busy` flag lets the control/hazard logic stall dependent HI/LO instructions.

## Interface

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (≥1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  qualifies md_op as a new operation this cycle
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- b  input  32  operand rt (divisor / multiplier)
- busy  output  1  registered; high while a mult/div is in flight
- hi  output  32  architectural HI register (mfhi source)
- lo  output  32  architectural LO register (mflo source)

## Operation

- State machine: IDLE, RUN. Internal: down-counter (width ≥ clog2(DIV_CYCLES)+1), pending HI/LO result registers, pending-writeback flag.
- IDLE, start=1, md_op∈{1..4}: compute result from a,b at this edge, store in pending registers, load counter with MULT_CYCLES or DIV_CYCLES, busy←1, go RUN.
- RUN: counter decrements each edge; on the edge where counter goes 1→0, hi/lo ← pending values (unless suppressed, see div-by-zero), busy←0, go IDLE.
- IDLE, start=1, md_op=5: hi←a; md_op=6: lo←a; takes effect at that edge, busy stays 0.
- start=1 while busy=1: ignored entirely (no operand latch, no mthi/mtlo write). Control logic guarantees stall; unit must still not corrupt state.
- start=0 or md_op∈{0,7}: no action.
- mult: signed 32×32→64, hi=product[63:32], lo=product[31:0]. multu: same, unsigned.
- div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- b=0 on div/divu: operation still occupies full DIV_CYCLES with busy=1; hi/lo left unchanged at completion.
- hi/lo outputs always show committed values; pending results never visible before completion.

## Timing

- Reset: busy=0, hi=0, lo=0, state IDLE, counter 0, pending cleared. Reset during RUN aborts the operation; no writeback occurs.
- Start accepted at edge E0 → busy=1 in cycles after E0 through edge E(N), N = MULT_CYCLES or DIV_CYCLES; busy high for exactly N cycles.
- hi/lo update at edge E(N), same edge busy falls; new values readable in the cycle after E(N).
- Back-to-back: a new start in the first cycle with busy=0 (i.e. after E(N)) is accepted at E(N+1); no dead cycle required.
- mthi/mtlo: 1-cycle, visible the cycle after the write edge.
- busy is a pure register output; stall logic combines `start | busy` externally.

## Test plan

- Reset then idle: assert reset 2 cycles → busy=0, hi=0, lo=0; start=0 for 20 cycles → unchanged.
- mult a=0xFFFFFFFE (−2), b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 → lo=3, hi=1; div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: mthi 0x11111111, mtlo 0x22222222, then divu a=5, b=0 → busy 10 cycles, hi/lo remain 0x11111111/0x22222222.
- start while busy: launch mult 3×4, issue mtlo 0xDEAD and a second mult in cycle 2 → ignored; final hi=0, lo=12 after 5 cycles.
- Reset mid-op: start div, assert reset at cycle 4 → busy=0, hi=lo=0 next cycle, no later writeback.
